// File: rtl/frame_sequencer.sv
// Frame sequencer: tags an untagged pixel stream with end-of-row/end-of-frame markers
// from a latched width/height config, one frame per start, with abort flush to the line buffer.
module frame_sequencer #(
    parameter int DATA_W    = 8,
    parameter int MAX_IMG_W = 640,
    parameter int MAX_IMG_H = 480,
    parameter int CNT_W     = $clog2(MAX_IMG_W + 1),
    parameter int ROW_W     = $clog2(MAX_IMG_H + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_cfg_width,
    input  logic [ROW_W-1:0]  i_cfg_height,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_rdy,
    input  logic              i_rdy,
    output logic              o_vld,
    output logic              o_eor,
    output logic              o_eof,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [15:0]       o_frame_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cfg_w;
    logic [ROW_W-1:0] cfg_h;
    logic [CNT_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             from_run;

    logic slot_free;
    logic accept;
    logic beat_eor;
    logic beat_eof;

    function automatic logic cfg_legal(input logic [CNT_W-1:0] w, input logic [ROW_W-1:0] h);
        return (w != '0) && (int'(w) <= MAX_IMG_W) && (h != '0) && (int'(h) <= MAX_IMG_H);
    endfunction

    // o_rdy depends only on state and the downstream side, never on i_vld
    assign slot_free = !o_vld || i_rdy;
    assign o_rdy     = (state == S_RUN) && slot_free;
    assign accept    = i_vld && o_rdy;
    assign beat_eor  = (col == cfg_w - CNT_W'(1));
    assign beat_eof  = beat_eor && (row == cfg_h - ROW_W'(1));
    assign o_busy    = (state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            cfg_w       <= '0;
            cfg_h       <= '0;
            col         <= '0;
            row         <= '0;
            from_run    <= 1'b0;
            o_vld       <= 1'b0;
            o_eor       <= 1'b0;
            o_eof       <= 1'b0;
            o_data      <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            // Slot drains by default; any load below overrides this
            if (slot_free) o_vld <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (cfg_legal(i_cfg_width, i_cfg_height)) begin
                            cfg_w <= i_cfg_width;
                            cfg_h <= i_cfg_height;
                            col   <= '0;
                            row   <= '0;
                            state <= S_RUN;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        o_vld  <= 1'b1;
                        o_data <= i_data;
                        o_eor  <= beat_eor;
                        o_eof  <= beat_eof;
                        if (beat_eor) begin
                            col <= '0;
                            row <= beat_eof ? '0 : row + ROW_W'(1);
                        end else begin
                            col <= col + CNT_W'(1);
                        end
                    end
                    // A completing eof beat takes priority over a coincident abort
                    if (accept && beat_eof) begin
                        state    <= S_DONE;
                        from_run <= 1'b1;
                    end else if (i_abort) begin
                        state    <= S_ABORT;
                        from_run <= 1'b0;
                    end
                end
                S_ABORT: begin
                    if (slot_free) begin
                        o_vld  <= 1'b1;
                        o_data <= '0;
                        o_eor  <= 1'b1;
                        o_eof  <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (slot_free) begin
                        o_done <= 1'b1;
                        state  <= S_IDLE;
                        if (from_run) o_frame_cnt <= o_frame_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer: random pixel traffic against a beat-index reference model
// (eor/eof derived from beat position, data from the offered pixel list).
module tb_frame_sequencer;

    localparam int DATA_W    = 8;
    localparam int MAX_IMG_W = 640;
    localparam int MAX_IMG_H = 480;
    localparam int CNT_W     = $clog2(MAX_IMG_W + 1);
    localparam int ROW_W     = $clog2(MAX_IMG_H + 1);

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_abort = 1'b0;
    logic [CNT_W-1:0]  i_cfg_width = '0;
    logic [ROW_W-1:0]  i_cfg_height = '0;
    logic              i_vld = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              o_rdy;
    logic              i_rdy = 1'b1;
    logic              o_vld;
    logic              o_eor;
    logic              o_eof;
    logic [DATA_W-1:0] o_data;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [15:0]       o_frame_cnt;

    frame_sequencer #(
        .DATA_W(DATA_W), .MAX_IMG_W(MAX_IMG_W), .MAX_IMG_H(MAX_IMG_H)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_cfg_width(i_cfg_width), .i_cfg_height(i_cfg_height),
        .i_vld(i_vld), .i_data(i_data), .o_rdy(o_rdy), .i_rdy(i_rdy),
        .o_vld(o_vld), .o_eor(o_eor), .o_eof(o_eof), .o_data(o_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_frame_cnt(o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int passes = 0;
    int exp_frames = 0;

    logic [DATA_W-1:0] pix[$];
    logic [DATA_W-1:0] ob_d[$];
    logic              ob_eor[$];
    logic              ob_eof[$];
    int sent, stall_err, done_cnt, done_cyc, eof_cyc, rdy_after_abort;
    bit timed_out;

    // Runs one frame from start until o_done (or budget), recording every beat taken downstream
    task automatic run_frame(input int w, input int h, input int rdy_pct, input int vld_pct,
                             input int abort_at, input bit abort_vld);
        int total;
        bit held, aborted;
        int abort_cyc;
        logic [DATA_W-1:0] hd;
        logic he, hf;
        total = w * h;
        held = 0; aborted = 0; abort_cyc = -1; hd = '0; he = 0; hf = 0;
        pix.delete(); ob_d.delete(); ob_eor.delete(); ob_eof.delete();
        for (int k = 0; k < total; k++) pix.push_back(DATA_W'($urandom));
        sent = 0; stall_err = 0; done_cnt = 0; done_cyc = -1; eof_cyc = -1; rdy_after_abort = 0;
        @(negedge i_clk);
        i_cfg_width = CNT_W'(w); i_cfg_height = ROW_W'(h);
        i_start = 1'b1; i_vld = 1'b0; i_abort = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (held && (o_vld !== 1'b1 || o_data !== hd || o_eor !== he || o_eof !== hf))
                stall_err++;
            if (o_done === 1'b1) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
            i_rdy = ($urandom_range(99) < rdy_pct);
            i_abort = 1'b0;
            if (abort_at >= 0 && !aborted && sent == abort_at) begin
                i_abort = 1'b1; aborted = 1; abort_cyc = cyc; i_vld = abort_vld;
            end else begin
                i_vld = (sent < total) && ($urandom_range(99) < vld_pct);
            end
            i_data = (sent < total) ? pix[sent] : DATA_W'($urandom);
            #1;
            if (aborted && cyc > abort_cyc && o_rdy === 1'b1) rdy_after_abort++;
            if (o_rdy === 1'b1 && i_vld) sent++;
            if (o_vld === 1'b1 && i_rdy) begin
                ob_d.push_back(o_data); ob_eor.push_back(o_eor); ob_eof.push_back(o_eof);
                if (o_eof === 1'b1) eof_cyc = cyc;
                held = 0;
            end else begin
                held = (o_vld === 1'b1); hd = o_data; he = o_eor; hf = o_eof;
            end
        end
        timed_out = (done_cnt == 0);
        i_vld = 1'b0; i_abort = 1'b0; i_rdy = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_vld, o_eor, o_eof, o_data, o_busy, o_done, o_err, o_frame_cnt, o_rdy} !== '0)
            $display("FAIL reset_outputs: got vld=%b eor=%b eof=%b data=%h busy=%b done=%b err=%b cnt=%0d rdy=%b, want all 0",
                     o_vld, o_eor, o_eof, o_data, o_busy, o_done, o_err, o_frame_cnt, o_rdy);
        else passes++;
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_frame(input string name, input int w, input int h,
                              input int rdy_pct, input int vld_pct);
        int total;
        bit exp_eor, exp_eof;
        total = w * h;
        run_frame(w, h, rdy_pct, vld_pct, -1, 0);
        exp_frames++;
        checks++;
        if (timed_out) $display("FAIL %s_timeout: no o_done within budget, want o_done", name);
        else passes++;
        checks++;
        if (ob_d.size() !== total)
            $display("FAIL %s_beat_count: got %0d beats, want %0d", name, ob_d.size(), total);
        else passes++;
        for (int n = 0; n < ob_d.size() && n < total; n++) begin
            exp_eor = ((n % w) == (w - 1));
            exp_eof = (n == total - 1);
            checks++;
            if ({ob_d[n], ob_eor[n], ob_eof[n]} !== {pix[n], exp_eor, exp_eof})
                $display("FAIL %s_beat%0d: got data=%h eor=%b eof=%b, want data=%h eor=%b eof=%b",
                         name, n, ob_d[n], ob_eor[n], ob_eof[n], pix[n], exp_eor, exp_eof);
            else passes++;
        end
        checks++;
        if (stall_err !== 0) $display("FAIL %s_stall_hold: %0d unstable stalled cycles, want 0", name, stall_err);
        else passes++;
        checks++;
        if (done_cnt !== 1) $display("FAIL %s_done_pulse: got %0d done cycles, want 1", name, done_cnt);
        else passes++;
        if (rdy_pct == 100 && vld_pct == 100) begin
            checks++;
            if (done_cyc !== eof_cyc + 1)
                $display("FAIL %s_done_latency: done at cycle %0d, want %0d", name, done_cyc, eof_cyc + 1);
            else passes++;
        end
        checks++;
        if (o_frame_cnt !== 16'(exp_frames) || o_busy !== 1'b0)
            $display("FAIL %s_frame_cnt: got cnt=%0d busy=%b, want cnt=%0d busy=0", name, o_frame_cnt, o_busy, exp_frames);
        else passes++;
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++)
            test_frame($sformatf("b2b%0d", f), $urandom_range(1, 6), $urandom_range(1, 3),
                       $urandom_range(30, 100), $urandom_range(30, 100));
    endtask

    task automatic test_abort();
        bit exp_eor;
        run_frame(3, 3, 100, 100, 4, 0);
        checks++;
        if (timed_out) $display("FAIL abort_timeout: no o_done within budget, want o_done");
        else passes++;
        checks++;
        if (ob_d.size() !== 5) $display("FAIL abort_beat_count: got %0d beats, want 5", ob_d.size());
        else passes++;
        for (int n = 0; n < ob_d.size() && n < 4; n++) begin
            exp_eor = ((n % 3) == 2);
            checks++;
            if ({ob_d[n], ob_eor[n], ob_eof[n]} !== {pix[n], exp_eor, 1'b0})
                $display("FAIL abort_beat%0d: got data=%h eor=%b eof=%b, want data=%h eor=%b eof=0",
                         n, ob_d[n], ob_eor[n], ob_eof[n], pix[n], exp_eor);
            else passes++;
        end
        if (ob_d.size() == 5) begin
            checks++;
            if ({ob_d[4], ob_eor[4], ob_eof[4]} !== {{DATA_W{1'b0}}, 1'b1, 1'b1})
                $display("FAIL abort_flush: got data=%h eor=%b eof=%b, want data=0 eor=1 eof=1",
                         ob_d[4], ob_eor[4], ob_eof[4]);
            else passes++;
        end
        checks++;
        if (rdy_after_abort !== 0) $display("FAIL abort_rdy_low: o_rdy high %0d cycles after abort, want 0", rdy_after_abort);
        else passes++;
        checks++;
        if (done_cnt !== 1 || o_frame_cnt !== 16'(exp_frames))
            $display("FAIL abort_done_cnt: got done=%0d cnt=%0d, want done=1 cnt=%0d", done_cnt, o_frame_cnt, exp_frames);
        else passes++;
    endtask

    task automatic test_cfg_err();
        int ws[4] = '{0, MAX_IMG_W + 1, 4, 4};
        int hs[4] = '{2, 2, 0, MAX_IMG_H + 1};
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            i_cfg_width = CNT_W'(ws[k]); i_cfg_height = ROW_W'(hs[k]); i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
            checks++;
            if (o_err !== 1'b1 || o_busy !== 1'b0)
                $display("FAIL cfg_err%0d_pulse: got err=%b busy=%b, want err=1 busy=0", k, o_err, o_busy);
            else passes++;
            @(negedge i_clk);
            checks++;
            if (o_err !== 1'b0 || o_busy !== 1'b0 || o_frame_cnt !== 16'(exp_frames))
                $display("FAIL cfg_err%0d_after: got err=%b busy=%b cnt=%0d, want err=0 busy=0 cnt=%0d",
                         k, o_err, o_busy, o_frame_cnt, exp_frames);
            else passes++;
        end
    endtask

    task automatic test_single_abort_same_cycle();
        run_frame(1, 1, 100, 100, 0, 1);
        exp_frames++;
        checks++;
        if (ob_d.size() !== 1) $display("FAIL single_beat_count: got %0d beats, want 1", ob_d.size());
        else passes++;
        if (ob_d.size() >= 1) begin
            checks++;
            if ({ob_d[0], ob_eor[0], ob_eof[0]} !== {pix[0], 1'b1, 1'b1})
                $display("FAIL single_beat: got data=%h eor=%b eof=%b, want data=%h eor=1 eof=1",
                         ob_d[0], ob_eor[0], ob_eof[0], pix[0]);
            else passes++;
        end
        checks++;
        if (timed_out || o_frame_cnt !== 16'(exp_frames))
            $display("FAIL single_frame_cnt: got cnt=%0d timeout=%0d, want cnt=%0d timeout=0", o_frame_cnt, timed_out, exp_frames);
        else passes++;
    endtask

    task automatic test_reset_midframe();
        int guard;
        @(negedge i_clk);
        i_cfg_width = CNT_W'(4); i_cfg_height = ROW_W'(3); i_start = 1'b1;
        sent = 0; guard = 0;
        while (sent < 6 && guard < 100) begin
            @(negedge i_clk);
            i_start = 1'b0; i_vld = 1'b1; i_rdy = 1'b1; i_data = DATA_W'($urandom);
            #1;
            if (o_rdy === 1'b1) sent++;
            guard++;
        end
        @(negedge i_clk);
        i_vld = 1'b0;
        checks++;
        if (sent !== 6) $display("FAIL midframe_fill: accepted %0d beats, want 6", sent);
        else passes++;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_vld, o_eor, o_eof, o_data, o_busy, o_done, o_err, o_frame_cnt, o_rdy} !== '0)
            $display("FAIL midframe_reset: got vld=%b eor=%b eof=%b data=%h busy=%b cnt=%0d rdy=%b, want all 0",
                     o_vld, o_eor, o_eof, o_data, o_busy, o_frame_cnt, o_rdy);
        else passes++;
        exp_frames = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_frame(2, 1, 100, 100, -1, 0);
        exp_frames++;
        checks++;
        if (ob_d.size() !== 2) $display("FAIL post_reset_count: got %0d beats, want 2", ob_d.size());
        else passes++;
        if (ob_d.size() == 2) begin
            checks++;
            if ({ob_eor[0], ob_eof[0], ob_eor[1], ob_eof[1]} !== 4'b0011)
                $display("FAIL post_reset_tags: got %b%b%b%b, want 0011", ob_eor[0], ob_eof[0], ob_eor[1], ob_eof[1]);
            else passes++;
        end
        checks++;
        if (o_frame_cnt !== 16'(exp_frames))
            $display("FAIL post_reset_cnt: got %0d, want %0d", o_frame_cnt, exp_frames);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_frame("full", 4, 2, 100, 100);
        test_frame("stall", 4, 2, 50, 100);
        test_back_to_back();
        test_abort();
        test_cfg_err();
        test_single_abort_same_cycle();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
